// File: rtl/seq_detect_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_pkg
// Brief    : Shared constants and helpers for the programmable sequence detector.
// Revision : 1.0 - initial release
// ============================================================================
package seq_detect_pkg;

  localparam int MODE_MEALY = 0;
  localparam int MODE_MOORE = 1;

  localparam logic [7:0] DEF_PATTERN = 8'b0000_1011;
  localparam int         DEF_LENGTH  = 4;

  // Width needed to hold a length in the range 0..pat_w.
  function automatic int len_w(input int pat_w);
    return $clog2(pat_w + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_detect_prog_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_prog_if
// Brief    : Serial-input, pattern-programming and match-report bundle.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_detect_prog_if
  import seq_detect_pkg::*;
#(
  parameter int PAT_W = 8,
  parameter int CNT_W = 8
) ();

  localparam int LEN_W = len_w(PAT_W);

  logic             x_valid;
  logic             x;
  logic             overlap_en;
  logic             pat_load;
  logic [PAT_W-1:0] pat_in;
  logic [LEN_W-1:0] len_in;
  logic             cnt_clr;
  logic             z;
  logic [CNT_W-1:0] match_cnt;
  logic             cnt_sat;

  modport master (
    output x_valid, x, overlap_en, pat_load, pat_in, len_in, cnt_clr,
    input  z, match_cnt, cnt_sat
  );

  modport slave (
    input  x_valid, x, overlap_en, pat_load, pat_in, len_in, cnt_clr,
    output z, match_cnt, cnt_sat
  );

endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : sat_counter
// Brief    : Saturating up-counter with clear; clear plus increment yields 1.
// Revision : 1.0 - initial release
// ============================================================================
module sat_counter #(
  parameter int W = 8
) (
  input  wire logic         clk,
  input  wire logic         rst_n,
  input  wire logic         clr,
  input  wire logic         inc,
  output logic      [W-1:0] q,
  output logic              sat
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (clr) begin
      r_q <= inc ? W'(1) : '0;
    end else if (inc && !(&r_q)) begin
      r_q <= r_q + W'(1);
    end
  end

  assign q   = r_q;
  assign sat = &r_q;

endmodule
`default_nettype wire

// File: rtl/seq_detect_prog.sv
`default_nettype none
// ============================================================================
// Module   : seq_detect_prog
// Brief    : Runtime-programmable serial pattern detector, Mealy or Moore output.
// Revision : 1.0 - initial release
// ============================================================================
module seq_detect_prog
  import seq_detect_pkg::*;
#(
  parameter int               PAT_W   = 8,
  parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'(DEF_PATTERN),
  parameter int               DEF_LEN = DEF_LENGTH,
  parameter int               MOORE   = MODE_MEALY,
  parameter int               CNT_W   = 8
) (
  input wire logic        clk,
  input wire logic        rst_n,
  seq_detect_prog_if.slave bus
);

  localparam int LEN_W = len_w(PAT_W);

  localparam logic [LEN_W-1:0] C_FILL_MAX = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] C_DEF_LEN  = LEN_W'(DEF_LEN);
  localparam logic [LEN_W-1:0] C_ONE      = LEN_W'(1);
  localparam logic [LEN_W:0]   C_ONE_EXT  = (LEN_W+1)'(1);

  logic [PAT_W-1:0] r_pat;
  logic [PAT_W-2:0] r_hist;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_fill;

  logic [PAT_W-1:0] w_hist_nxt;
  logic [PAT_W-1:0] w_mask;
  logic             w_eq;
  logic             w_len_ok;
  logic             w_hit;
  logic [CNT_W-1:0] w_cnt;
  logic             w_sat;

  always_comb begin
    w_mask     = '0;
    w_hist_nxt = {r_hist, bus.x};
    for (int i = 0; i < PAT_W; i++) begin
      w_mask[i] = (i < int'(r_len));
    end
    // Only the low len_reg bits take part in the comparison.
    w_eq     = (((w_hist_nxt ^ r_pat) & w_mask) == '0);
    w_len_ok = (({1'b0, r_fill} + C_ONE_EXT) >= {1'b0, r_len});
    w_hit    = rst_n & bus.x_valid & ~bus.pat_load & w_len_ok & w_eq;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pat  <= DEF_PAT;
      r_len  <= C_DEF_LEN;
      r_hist <= '0;
      r_fill <= '0;
    end else if (bus.pat_load) begin
      r_pat  <= bus.pat_in;
      r_len  <= (bus.len_in == '0) ? C_FILL_MAX : bus.len_in;
      r_hist <= '0;
      r_fill <= '0;
    end else if (bus.x_valid) begin
      r_hist <= w_hist_nxt[PAT_W-2:0];
      // Non-overlap restarts the fill so the next match needs fresh bits.
      if (w_hit && !bus.overlap_en) begin
        r_fill <= '0;
      end else if (r_fill != C_FILL_MAX) begin
        r_fill <= r_fill + C_ONE;
      end
    end
  end

  generate
    if (MOORE == MODE_MOORE) begin : g_moore
      logic r_z;
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          r_z <= 1'b0;
        end else begin
          r_z <= w_hit;
        end
      end
      assign bus.z = r_z;
    end else begin : g_mealy
      assign bus.z = w_hit;
    end
  endgenerate

  sat_counter #(
    .W (CNT_W)
  ) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (bus.cnt_clr),
    .inc   (w_hit),
    .q     (w_cnt),
    .sat   (w_sat)
  );

  assign bus.match_cnt = w_cnt;
  assign bus.cnt_sat   = w_sat;

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_prog.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_detect_prog
// Brief    : Mealy/CNT_W=8 and Moore/CNT_W=2 detectors driven in lockstep.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_detect_prog;
  import seq_detect_pkg::*;

  localparam int PAT_W = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  seq_detect_prog_if #(.PAT_W(PAT_W), .CNT_W(8)) if_a ();
  seq_detect_prog_if #(.PAT_W(PAT_W), .CNT_W(2)) if_b ();

  seq_detect_prog #(
    .PAT_W(PAT_W), .DEF_PAT(8'b0000_1011), .DEF_LEN(4), .MOORE(MODE_MEALY), .CNT_W(8)
  ) u_dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a.slave));

  seq_detect_prog #(
    .PAT_W(PAT_W), .DEF_PAT(8'b0000_1011), .DEF_LEN(4), .MOORE(MODE_MOORE), .CNT_W(2)
  ) u_dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b.slave));

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  // Reference state: accepted bits since last clear, oldest first.
  bit         m_q[$];
  logic [7:0] m_pat;
  int         m_len;
  int         m_cnt_a;
  int         m_cnt_b;
  bit         m_zb;

  task automatic check(input string tag, input int obs, input int exp);
    n_total++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic bit model_hit(input bit rn, input bit v, input bit xb, input bit ld);
    bit b;
    if (!rn || !v || ld) return 1'b0;
    if (m_q.size() + 1 < m_len) return 1'b0;
    for (int i = 0; i < m_len; i++) begin
      b = (i == 0) ? xb : m_q[m_q.size() - i];
      if (b != m_pat[i]) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic step(input bit rn, input bit v, input bit xb, input bit ov,
                      input bit ld, input logic [7:0] pi, input int li, input bit clr);
    bit hit;
    rst_n = rn;
    if_a.x_valid = v;  if_b.x_valid = v;
    if_a.x = xb;       if_b.x = xb;
    if_a.overlap_en = ov; if_b.overlap_en = ov;
    if_a.pat_load = ld;   if_b.pat_load = ld;
    if_a.pat_in = pi;     if_b.pat_in = pi;
    if_a.len_in = 4'(li); if_b.len_in = 4'(li);
    if_a.cnt_clr = clr;   if_b.cnt_clr = clr;
    @(negedge clk);
    hit = model_hit(rn, v, xb, ld);
    if (chk_en) begin
      check("z_mealy", int'(if_a.z), int'(hit));
      check("z_moore", int'(if_b.z), int'(m_zb));
      check("cnt_a", int'(if_a.match_cnt), m_cnt_a);
      check("cnt_b", int'(if_b.match_cnt), m_cnt_b);
      check("sat_b", int'(if_b.cnt_sat), int'(m_cnt_b == 3));
    end
    @(posedge clk);
    if (!rn) begin
      m_pat = 8'b0000_1011; m_len = 4; m_q.delete();
      m_zb = 1'b0; m_cnt_a = 0; m_cnt_b = 0;
    end else begin
      if (clr) begin
        m_cnt_a = int'(hit); m_cnt_b = int'(hit);
      end else if (hit) begin
        if (m_cnt_a < 255) m_cnt_a++;
        if (m_cnt_b < 3) m_cnt_b++;
      end
      m_zb = hit;
      if (ld) begin
        m_pat = pi; m_len = (li == 0) ? PAT_W : li; m_q.delete();
      end else if (v) begin
        m_q.push_back(xb);
        if (m_q.size() > PAT_W) void'(m_q.pop_front());
        if (hit && !ov) m_q.delete();
      end
    end
    #1;
  endtask

  task automatic bit1(input bit xb, input bit ov);
    step(1'b1, 1'b1, xb, ov, 1'b0, 8'h00, 0, 1'b0);
  endtask

  task automatic idle();
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0);
  endtask

  task automatic send_stream(input logic [15:0] s, input bit ov);
    for (int i = 15; i >= 0; i--) bit1(s[i], ov);
  endtask

  initial begin
    logic [15:0] s1;
    logic [15:0] s2;
    s1 = 16'b1011000010110111;
    s2 = 16'b1000010010010011;

    do_reset();
    chk_en = 1'b1;
    check("rst_cnt_a", int'(if_a.match_cnt), 0);
    check("rst_cnt_b", int'(if_b.match_cnt), 0);
    check("rst_z_moore", int'(if_b.z), 0);
    check("rst_sat_b", int'(if_b.cnt_sat), 0);

    send_stream(s1, 1'b1);
    check("ovl_cnt", int'(if_a.match_cnt), 3);

    do_reset();
    send_stream(s1, 1'b0);
    check("novl_cnt", int'(if_a.match_cnt), 2);

    do_reset();
    step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 8'b0000_1001, 4, 1'b0);
    send_stream(s2, 1'b1);
    check("p1001_ovl_cnt", int'(if_a.match_cnt), 3);
    step(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'b0000_1001, 4, 1'b0);
    send_stream(s2, 1'b0);
    check("p1001_novl_cnt", int'(if_a.match_cnt), 2);

    do_reset();
    bit1(1'b1, 1'b1); idle(); bit1(1'b0, 1'b1); idle(); idle();
    bit1(1'b1, 1'b1); idle(); bit1(1'b1, 1'b1);
    check("stall_cnt", int'(if_a.match_cnt), 1);

    do_reset();
    bit1(1'b1, 1'b1); bit1(1'b0, 1'b1); bit1(1'b1, 1'b1);
    do_reset();
    bit1(1'b1, 1'b1);
    check("midrst_cnt", int'(if_a.match_cnt), 0);
    bit1(1'b0, 1'b1); bit1(1'b1, 1'b1); bit1(1'b1, 1'b1);
    check("midrst_defpat", int'(if_a.match_cnt), 1);

    do_reset();
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'b0000_0001, 1, 1'b0);
    for (int i = 0; i < 6; i++) bit1(1'b1, 1'b0);
    check("sat_cnt_b", int'(if_b.match_cnt), 3);
    check("sat_flag_b", int'(if_b.cnt_sat), 1);
    check("len1_cnt_a", int'(if_a.match_cnt), 6);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1'b1);
    check("clr_hit_b", int'(if_b.match_cnt), 1);

    for (int i = 0; i < 800; i++) begin
      bit         rn, v, xb, ov, ld, clr;
      logic [7:0] pi;
      int         li;
      rn  = ($urandom_range(0, 99) != 0);
      v   = ($urandom_range(0, 3) != 0);
      xb  = 1'($urandom);
      ov  = 1'($urandom);
      ld  = ($urandom_range(0, 39) == 0);
      clr = ($urandom_range(0, 29) == 0);
      pi  = 8'($urandom);
      li  = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 8) : $urandom_range(1, 4);
      step(rn, v, xb, ov, ld, pi, li, clr);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
